// File: rtl/sdrstick_pkg.sv
// sdrstick_pkg: shared framer state encoding, control register map and header defaults.
package sdrstick_pkg;
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HDR     = 2'd1,
      TS      = 2'd2,
      PAYLOAD = 2'd3
   } state_t;
   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_FRAMES = 2'd1;
   localparam logic [1:0] REG_SEQ    = 2'd2;
   localparam logic [1:0] REG_PADERR = 2'd3;
   localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;
endpackage

// File: rtl/sdrstick_rx_framer_if.sv
// sdrstick_rx_framer_if: Avalon-ST source (ready latency 0) carrying frames to the DMA engine.
interface sdrstick_rx_framer_if;
   logic [31:0] data;
   logic        valid;
   logic        ready;
   logic        startofpacket;
   logic        endofpacket;
   modport master (output data, valid, startofpacket, endofpacket, input ready);
   modport slave (input data, valid, startofpacket, endofpacket, output ready);
endinterface

// File: rtl/sdrstick_rx_framer_regs.sv
// sdrstick_rx_framer_regs: control/status registers, frame/sequence/pad-error counters and the clear pulse.
module sdrstick_rx_framer_regs
   import sdrstick_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  ctl_address,
   input  logic        ctl_read,
   input  logic        ctl_write,
   input  logic [31:0] ctl_writedata,
   input  logic        frame_done,
   input  logic        pad_hit,
   output logic        enable,
   output logic [15:0] seq,
   output logic [31:0] ctl_readdata
);
   logic [31:0] frames;
   logic [31:0] pad_err;
   logic [31:0] rd_mux;
   logic        ctrl_wr;
   logic        clear;
   logic        unused_wdata;
   assign unused_wdata = ^ctl_writedata[31:2];
   assign ctrl_wr = ctl_write && ctl_address == REG_CTRL;
   assign clear   = ctrl_wr && ctl_writedata[1];
   always_comb
      rd_mux = ctl_address == REG_CTRL   ? {31'd0, enable} :
               ctl_address == REG_FRAMES ? frames :
               ctl_address == REG_SEQ    ? {16'd0, seq} :
                                           pad_err;
   // clear has priority over a frame completing in the same cycle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         enable       <= 1'b0;
         seq          <= '0;
         frames       <= '0;
         pad_err      <= '0;
         ctl_readdata <= '0;
      end else begin
         if (ctrl_wr)
            enable <= ctl_writedata[0];
         if (ctl_read)
            ctl_readdata <= rd_mux;
         if (clear) begin
            seq     <= '0;
            frames  <= '0;
            pad_err <= '0;
         end else begin
            if (frame_done) begin
               seq    <= seq + 16'd1;
               frames <= frames + 32'd1;
            end
            if (pad_hit && pad_err != '1)
               pad_err <= pad_err + 32'd1;
         end
      end
   end
endmodule

// File: rtl/sdrstick_rx_framer.sv
// sdrstick_rx_framer: pops I/Q words from the sample FIFO and wraps every PAIRS_PER_FRAME pairs into a frame.
// Define SDRSTICK_RX_FRAMER_TIMESTAMP_EN to insert a latched clk-counter word between header and payload.
module sdrstick_rx_framer
   import sdrstick_pkg::*;
#(
   parameter int         PAIRS_PER_FRAME = 63,
   parameter logic [7:0] MAGIC           = MAGIC_DEFAULT
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic [31:0]                 fifo_readdata,
   input  logic                        fifo_empty,
   output logic                        fifo_read,
   sdrstick_rx_framer_if.master        src,
   input  logic [1:0]                  ctl_address,
   input  logic                        ctl_read,
   output logic [31:0]                 ctl_readdata,
   input  logic                        ctl_write,
   input  logic [31:0]                 ctl_writedata
);
   localparam logic [8:0] LAST = 9'(2 * PAIRS_PER_FRAME - 1);
   state_t      state;
   logic [8:0]  wcnt;
   logic [31:0] hold_data;
   logic        hold_valid;
   logic        fire;
   logic        last;
   logic        start;
   logic        enable;
   logic        frame_done;
   logic        pad_hit;
   logic [15:0] seq;
   logic [31:0] ts_word;
`ifdef SDRSTICK_RX_FRAMER_TIMESTAMP_EN
   localparam state_t AFTER_HDR = TS;
   logic [31:0] ts_cnt;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ts_cnt  <= '0;
         ts_word <= '0;
      end else begin
         ts_cnt <= ts_cnt + 32'd1;
         if (start)
            ts_word <= ts_cnt;
      end
   end
`else
   localparam state_t AFTER_HDR = PAYLOAD;
   assign ts_word = '0;
`endif
   // payload words bypass the hold register so FIFO head reaches the DMA with no added latency
   assign fire              = src.valid && src.ready;
   assign last              = wcnt == LAST;
   assign start             = state == IDLE && enable && !fifo_empty;
   assign src.valid         = state == PAYLOAD ? !fifo_empty : hold_valid;
   assign src.data          = state == PAYLOAD ? fifo_readdata : hold_data;
   assign src.startofpacket = state == HDR;
   assign src.endofpacket   = state == PAYLOAD && last;
   assign fifo_read         = state == PAYLOAD && fire;
   assign frame_done        = fifo_read && last;
   assign pad_hit           = fifo_read && |fifo_readdata[31:24];
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         hold_valid <= 1'b0;
         hold_data  <= '0;
         wcnt       <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               state      <= HDR;
               hold_valid <= 1'b1;
               hold_data  <= {MAGIC, 8'(PAIRS_PER_FRAME), seq};
            end
            HDR: if (src.ready) begin
               state      <= AFTER_HDR;
               hold_valid <= AFTER_HDR == TS;
               hold_data  <= ts_word;
            end
            TS: if (src.ready) begin
               state      <= PAYLOAD;
               hold_valid <= 1'b0;
            end
            PAYLOAD: if (fire) begin
               state <= last ? IDLE : PAYLOAD;
               wcnt  <= last ? '0 : wcnt + 9'd1;
            end
            default: state <= IDLE;
         endcase
      end
   end
   sdrstick_rx_framer_regs u_regs (
      .clk           (clk),
      .reset_n       (reset_n),
      .ctl_address   (ctl_address),
      .ctl_read      (ctl_read),
      .ctl_write     (ctl_write),
      .ctl_writedata (ctl_writedata),
      .frame_done    (frame_done),
      .pad_hit       (pad_hit),
      .enable        (enable),
      .seq           (seq),
      .ctl_readdata  (ctl_readdata)
   );
endmodule

// File: tb/tb_sdrstick_rx_framer.sv
// tb_sdrstick_rx_framer: directed and randomized checks of the framer against a stream-level frame model.
`timescale 1ns/1ps
module tb_sdrstick_rx_framer;
   import sdrstick_pkg::*;
   localparam int N = 2;
`ifdef SDRSTICK_RX_FRAMER_TIMESTAMP_EN
   localparam int TSW = 1;
`else
   localparam int TSW = 0;
`endif
   localparam int FLEN = 1 + TSW + 2 * N;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] fifo_readdata;
   logic        fifo_empty;
   logic        fifo_read;
   logic [1:0]  ctl_address;
   logic        ctl_read;
   logic        ctl_write;
   logic [31:0] ctl_writedata;
   logic [31:0] ctl_readdata;
   sdrstick_rx_framer_if src();
   sdrstick_rx_framer #(.PAIRS_PER_FRAME(N)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .fifo_readdata (fifo_readdata),
      .fifo_empty    (fifo_empty),
      .fifo_read     (fifo_read),
      .src           (src),
      .ctl_address   (ctl_address),
      .ctl_read      (ctl_read),
      .ctl_readdata  (ctl_readdata),
      .ctl_write     (ctl_write),
      .ctl_writedata (ctl_writedata)
   );
   always #5 clk = ~clk;
   int          checks = 0;
   int          errors = 0;
   logic [31:0] fifo_q[$];
   logic [31:0] sent[$];
   logic [31:0] got[$];
   int          rd_idx = 0;
   int          pos = 0;
   int          pops = 0;
   logic [15:0] m_seq = '0;
   logic [31:0] m_frames = '0;
   logic [31:0] m_pad = '0;
   logic        prev_stall = 1'b0;
   logic        prev_valid = 1'b0;
   logic        prev_sop = 1'b0;
   logic [31:0] prev_data = '0;
   logic [1:0]  prev_se = '0;
   logic [31:0] ts_model = '0;
   logic [31:0] prev_ts = '0;
   logic [31:0] ts_exp = '0;
   logic        pop_now;
   int          g0;
   always @(posedge clk) ts_model <= reset_n ? ts_model + 32'd1 : 32'd0;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask
   task automatic drive_fifo();
      fifo_empty    = fifo_q.size() == 0;
      fifo_readdata = fifo_empty ? 32'd0 : fifo_q[0];
   endtask
   task automatic push(input logic [31:0] w);
      fifo_q.push_back(w);
      sent.push_back(w);
      drive_fifo();
   endtask
   // the stream is a sequence of frames: header, optional timestamp, then the next 2N FIFO words in order
   task automatic check();
      logic        hs;
      logic        pay;
      logic [31:0] ew;
      hs  = src.valid && src.ready;
      pay = pos > TSW;
      if (prev_stall) begin
         chk("stall_valid", {31'd0, src.valid}, 32'd1);
         chk("stall_data", src.data, prev_data);
         chk("stall_sop_eop", {30'd0, src.startofpacket, src.endofpacket}, {30'd0, prev_se});
      end
      chk("fifo_read", {31'd0, fifo_read}, {31'd0, hs && pay});
      if (src.valid && src.startofpacket && !(prev_valid && prev_sop))
         ts_exp = prev_ts;
      if (hs) begin
         got.push_back(src.data);
         if (pos == 0)
            ew = {8'hA5, 8'(N), m_seq};
         else if (!pay)
            ew = ts_exp;
         else
            ew = rd_idx < sent.size() ? sent[rd_idx] : 32'hDEADBEEF;
         chk("data", src.data, ew);
         chk("sop_eop", {30'd0, src.startofpacket, src.endofpacket}, {30'd0, pos == 0, pos == FLEN - 1});
         if (pay) begin
            if (|ew[31:24] && m_pad != '1)
               m_pad++;
            rd_idx++;
         end
         pos++;
         if (pos == FLEN) begin
            pos = 0;
            m_seq++;
            m_frames++;
         end
      end
      if (ctl_write && ctl_address == REG_CTRL && ctl_writedata[1]) begin
         m_seq    = '0;
         m_frames = '0;
         m_pad    = '0;
      end
      if (fifo_read)
         pops++;
      prev_stall = src.valid && !src.ready;
      prev_valid = src.valid;
      prev_sop   = src.startofpacket;
      prev_data  = src.data;
      prev_se    = {src.startofpacket, src.endofpacket};
      prev_ts    = ts_model;
   endtask
   task automatic tick();
      @(negedge clk);
      check();
      pop_now = fifo_read;
      @(posedge clk);
      #1;
      if (pop_now && fifo_q.size() > 0)
         fifo_q.delete(0);
      drive_fifo();
   endtask
   task automatic run(input int n);
      repeat (n) tick();
   endtask
   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      ctl_address   = a;
      ctl_writedata = d;
      ctl_write     = 1'b1;
      tick();
      ctl_write     = 1'b0;
      ctl_writedata = '0;
   endtask
   task automatic rd(input string name, input logic [1:0] a, input logic [31:0] exp);
      ctl_address = a;
      ctl_read    = 1'b1;
      tick();
      ctl_read    = 1'b0;
      chk(name, ctl_readdata, exp);
   endtask
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end
   initial begin
      ctl_address   = '0;
      ctl_read      = 1'b0;
      ctl_write     = 1'b0;
      ctl_writedata = '0;
      src.ready     = 1'b1;
      drive_fifo();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", {31'd0, src.valid}, 32'd0);
      chk("rst_sop", {31'd0, src.startofpacket}, 32'd0);
      chk("rst_eop", {31'd0, src.endofpacket}, 32'd0);
      chk("rst_fifo_read", {31'd0, fifo_read}, 32'd0);
      chk("rst_readdata", ctl_readdata, 32'd0);
      @(posedge clk);
      #1 reset_n = 1'b1;
      // disabled: words wait in the FIFO untouched
      push(32'h00111111); push(32'h00222222); push(32'h00333333); push(32'h00444444);
      run(3);
      chk("disabled_fifo_level", fifo_q.size(), 32'd4);
      chk("disabled_valid", {31'd0, src.valid}, 32'd0);
      g0 = got.size();
      wr(REG_CTRL, 32'd1);
      run(12);
      chk("t1_len", got.size() - g0, FLEN);
      chk("t1_hdr", got[g0], 32'hA5020000);
      chk("t1_i0", got[g0 + TSW + 1], 32'h00111111);
      chk("t1_q1", got[g0 + TSW + 4], 32'h00444444);
      chk("t1_pops", pops, 32'd4);
      rd("t1_seq", REG_SEQ, 32'd1);
      rd("t1_frames", REG_FRAMES, 32'd1);
      // ready 1-0-0-1 stalls, with one padded word forwarded untouched
      push(32'h00555555); push(32'h01123456); push(32'h00777777); push(32'h00888888);
      for (int i = 0; i < 24; i++) begin
         src.ready = (i % 4 == 0) || (i % 4 == 3);
         tick();
      end
      src.ready = 1'b1;
      chk("t2_pops", pops, 32'd8);
      rd("t2_pad_err", REG_PADERR, 32'd1);
      rd("t2_seq", REG_SEQ, 32'd2);
      // FIFO underrun mid-payload
      push(32'h00A00001); push(32'h00A00002); push(32'h00A00003);
      run(8);
      chk("underrun_valid", {31'd0, src.valid}, 32'd0);
      chk("underrun_pops", pops, 32'd11);
      push(32'h00A00004);
      run(5);
      push(32'h00B00001); push(32'h00B00002); push(32'h00B00003); push(32'h00B00004);
      run(12);
      rd("t3_seq", REG_SEQ, 32'd4);
      // disable after the header: frame completes, remaining words stay queued
      for (int i = 0; i < 8; i++) push(32'h00C00000 + 32'(i));
      for (int i = 0; i < 10 && pos == 0; i++) tick();
      wr(REG_CTRL, 32'd0);
      run(20);
      chk("t4_fifo_level", fifo_q.size(), 32'd4);
      chk("t4_valid", {31'd0, src.valid}, 32'd0);
      rd("t4_frames", REG_FRAMES, 32'd5);
      wr(REG_CTRL, 32'd1);
      run(12);
      rd("t4_frames_after", REG_FRAMES, 32'd6);
      // randomized traffic, ready and enable
      for (int i = 0; i < 1500; i++) begin
         src.ready = $urandom_range(0, 3) != 0;
         if ($urandom_range(0, 2) == 0 && fifo_q.size() < 16)
            push({($urandom_range(0, 9) == 0) ? 8'($urandom_range(1, 255)) : 8'h00, 24'($urandom)});
         if ($urandom_range(0, 199) == 0)
            wr(REG_CTRL, 32'($urandom_range(0, 1)));
         else
            tick();
      end
      wr(REG_CTRL, 32'd1);
      src.ready = 1'b1;
      while (sent.size() % (2 * N) != 0)
         push({8'h00, 24'($urandom)});
      for (int i = 0; i < 500 && (fifo_q.size() != 0 || pos != 0); i++) tick();
      run(4);
      chk("rand_drained", {31'd0, fifo_q.size() == 0 && pos == 0}, 32'd1);
      rd("rand_frames", REG_FRAMES, m_frames);
      rd("rand_seq", REG_SEQ, {16'd0, m_seq});
      rd("rand_pad_err", REG_PADERR, m_pad);
      // clear lands on the same edge as the eop handshake
      push(32'h00D00001); push(32'h00D00002); push(32'h00D00003); push(32'h00D00004);
      for (int i = 0; i < 20 && pos != FLEN - 1; i++) tick();
      src.ready = 1'b0;
      chk("t6_eop_present", {31'd0, src.endofpacket}, 32'd1);
      src.ready = 1'b1;
      wr(REG_CTRL, 32'd3);
      rd("t6_frames", REG_FRAMES, 32'd0);
      rd("t6_seq", REG_SEQ, 32'd0);
      rd("t6_pad_err", REG_PADERR, 32'd0);
      // sequence wrap from FFFF
      force dut.u_regs.seq = 16'hFFFF;
      tick();
      release dut.u_regs.seq;
      m_seq = 16'hFFFF;
      g0 = got.size();
      push(32'h00E00001); push(32'h00E00002); push(32'h00E00003); push(32'h00E00004);
      run(12);
      chk("wrap_hdr", got[g0], 32'hA502FFFF);
      rd("wrap_seq", REG_SEQ, 32'd0);
      rd("wrap_frames", REG_FRAMES, 32'd1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/sdrstick_rx_framer.md
# sdrstick_rx_framer

Read-side consumer of the receiver sample FIFO, clocked in the CPU/DMA `clk` domain. It pops the alternating I/Q words written by the receiver (`{8'b0, I[23:0]}`, then `{8'b0, Q[23:0]}`) and wraps each block of N I/Q pairs into a frame. Each frame carries a header with a sequence number. Frames leave on an Avalon-ST source that feeds the DMA engine, and a small control/status register interface sits on the same control bus as the receiver.

## Interface
Parameters:
- `PAIRS_PER_FRAME`, default 63: I/Q pairs per frame. Range 1..255.
- `MAGIC`, default 8'hA5: header bits [31:24].

Ports:
- `clk` in 1: system clock.
- `reset_n` in 1: one clock; reset is asynchronous and active-low.
- `fifo_readdata` in 32: FIFO head word. Show-ahead: valid whenever `!fifo_empty`.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_read` out 1: pop strobe. Combinational.
- `src_data` out 32: stream data.
- `src_valid` out 1: stream valid.
- `src_ready` in 1: DMA ready.
- `src_startofpacket` out 1: marks the header word.
- `src_endofpacket` out 1: marks the last payload word.
- `ctl_address` in 2: register select.
- `ctl_read` in 1: register read strobe.
- `ctl_readdata` out 32: read data, registered, valid on the cycle after `ctl_read`.
- `ctl_write` in 1: register write strobe.
- `ctl_writedata` in 32: write data.

## Operation
Registers:
- 0 CTRL: bit0 `enable` (RW). Bit1 `clear`: write-1 pulse that zeroes `seq`, `frames` and `pad_err`. Reads as 0.
- 1 `frames` (RO): count of completed frames, wraps at 2^32.
- 2 `seq` (RO): sequence number the next frame will carry.
- 3 `pad_err` (RO): count of popped payload words with bits [31:24] != 0. Saturates at 32'hFFFFFFFF.

States:
- IDLE -> HDR when `enable` is set and `!fifo_empty`.
- HDR: drives `{MAGIC, 8'(PAIRS_PER_FRAME), seq[15:0]}` with sop=1. On handshake -> TS if compiled in, else PAYLOAD.
- TS: drives `ts_latched` (see Configuration). On handshake -> PAYLOAD.
- PAYLOAD: streams `2*PAIRS_PER_FRAME` words.
  - `src_valid = !fifo_empty`, `src_data = fifo_readdata`.
  - `fifo_read = src_valid & src_ready`.
  - Word counter `wcnt` increments on each handshake.
  - eop=1 when `wcnt == 2*PAIRS_PER_FRAME-1`.
  - On the eop handshake: `seq++`, `frames++`, -> IDLE.

Rules:
- A frame is never cut. Clearing `enable` mid-frame takes effect in IDLE only.
- The FIFO is never popped outside PAYLOAD. Data left in the FIFO while disabled stays there.
- `clear` arriving on the same cycle as a frame completion: the counters end at 0 (clear wins).
- `seq` is 16 bits and wraps from FFFF to 0000.
- The payload word is forwarded unmodified. `pad_err` only counts words with a nonzero top byte.

Reset values: state IDLE, `src_valid` 0, sop 0, eop 0, `fifo_read` 0, `ctl_readdata` 0, `enable` 0, all counters 0.

## Timing
- IDLE->HDR costs one cycle. The header is registered and `src_valid` rises the cycle after the trigger.
- Avalon-ST ready latency 0:
  - `src_data`, sop and eop are held stable while `src_valid & !src_ready`.
  - `src_valid` in HDR/TS never drops before its handshake.
- PAYLOAD has zero added latency. FIFO head to `src_data` is combinational, and one word moves per cycle when the FIFO is non-empty and ready is high.
- In PAYLOAD, `src_valid` may deassert when the FIFO underruns, and resumes without loss.
- Minimum frame length is 1 + TS + 2N cycles. A full FIFO plus constant ready gives back-to-back frames separated by one IDLE cycle.
- Reset asserted mid-frame aborts the frame immediately. The words already popped are lost, and the DMA sees no eop.

## Configuration
- `SDRSTICK_RX_FRAMER_TIMESTAMP_EN` defined:
  - A free-running 32-bit `clk` counter is latched on the IDLE->HDR transition.
  - That value is sent as one extra word, the TS state, between header and payload.
  - The header bit [23:16] length field is unchanged (pairs only).
- Undefined: the TS state, the counter and the latch are absent, and the frame is header plus payload.

## Structure
- Shared package `sdrstick_pkg` holds:
  - the state enum (IDLE/HDR/TS/PAYLOAD);
  - register address constants (`REG_CTRL`, `REG_FRAMES`, `REG_SEQ`, `REG_PADERR`);
  - the `MAGIC` default.
- One sub-module, `sdrstick_rx_framer_regs`, holds the control/status registers and counters with the clear pulse. The FSM and datapath stay in the top.

## Test plan
- N=2, enable, preload FIFO with I0,Q0,I1,Q1 (24-bit values, zero pad), ready=1 -> stream `A5020000`, I0,Q0,I1,Q1. sop on word 0, eop on word 4. `seq` and `frames` become 1.
- Same stream with `src_ready` toggling 1-0-0-1 -> data, sop and eop held stable through the stalls, no duplicated or dropped words, `fifo_read` pulses exactly 4 times.
- FIFO empties after 3 payload words -> `src_valid` drops. Push Q1 -> frame completes with eop, and the next header carries seq 0001.
- Clear `enable` after the header handshake -> the current frame finishes, then the block stays in IDLE with the FIFO untouched.
- Force `seq` to FFFF via 65535 frames (or backdoor), send one frame -> header low half FFFF, then `seq` reads 0000. Clear concurrent with eop -> `frames` reads 0.
- Payload word `0x01123456` -> `pad_err`=1 and the word is forwarded unchanged. With `SDRSTICK_RX_FRAMER_TIMESTAMP_EN`, word 1 equals the counter value captured at the HDR transition.
